// File: rtl/normalizador_iter.sv
// normalizador_iter: iterative left-normaliser for fixed-point operands.
// Shifts the operand left by up to STEP bits per cycle until its MSB is set,
// then reports the mantissa, the signed binary exponent and zero/sign flags.
// Optional feature macro: NORM_SIGNED_EN (two's complement operand; when it is
// undefined the operand is unsigned and no negation logic exists).
module normalizador_iter #(
    parameter int W    = 32,
    parameter int FRAC = 24,
    parameter int EW   = 8,
    parameter int STEP = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [W-1:0]  A,
    output logic          BUSY,
    output logic          DONE,
    output logic [W-1:0]  Y,
    output logic [EW-1:0] E,
    output logic          ZERO,
    output logic          SIGN
);

    localparam int CW = $clog2(W + 1);
    // Exponent of an operand whose MSB is already set (no shift applied).
    localparam logic [EW-1:0] E_TOP = EW'(W - 1 - FRAC);

    typedef enum logic {
        IDLE,
        NORM
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   r_q, r_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   y_q, y_d;
    logic [EW-1:0]  e_q, e_d;
    logic           zero_q, zero_d;
    logic [W-1:0]   mag;
    logic [CW-1:0]  lz_k;
    logic           lz_found;
    logic           top_zero;
    logic           finish;

`ifdef NORM_SIGNED_EN
    logic sgn_q, sgn_d;
    logic sign_q, sign_d;

    // Magnitude of a two's complement operand; -2^(W-1) wraps to 2^(W-1).
    assign mag = A[W-1] ? (~A + W'(1)) : A;
`else
    // Unsigned operand: the magnitude is the operand itself.
    assign mag = A;
`endif

    // Leading-zero count restricted to the top STEP bits of the working value.
    always_comb begin
        lz_k     = '0;
        lz_found = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (!lz_found) begin
                if (r_q[W-1-i]) lz_found = 1'b1;
                else            lz_k     = lz_k + CW'(1);
            end
        end
    end

    assign top_zero = (r_q[W-1 -: STEP] == '0);

    // Next-state and result computation for the IDLE/NORM sequencer.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        y_d     = y_q;
        e_d     = e_q;
        zero_d  = zero_q;
        finish  = 1'b0;
`ifdef NORM_SIGNED_EN
        sgn_d   = sgn_q;
        sign_d  = sign_q;
`endif
        case (state_q)
            IDLE: begin
                if (START) begin
                    r_d     = mag;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = NORM;
`ifdef NORM_SIGNED_EN
                    sgn_d   = A[W-1];
`endif
                end
            end
            NORM: begin
                if (r_q == '0) begin
                    finish = 1'b1;
                    y_d    = '0;
                    e_d    = '0;
                    zero_d = 1'b1;
                end else if (r_q[W-1]) begin
                    finish = 1'b1;
                    y_d    = r_q;
                    e_d    = E_TOP - EW'(cnt_q);
                    zero_d = 1'b0;
                end else if (top_zero) begin
                    // Whole step is empty: shift it out and keep iterating.
                    r_d   = r_q << STEP;
                    cnt_d = cnt_q + CW'(STEP);
                end else begin
                    // Final partial shift; the leading one lies inside this step.
                    finish = 1'b1;
                    y_d    = r_q << lz_k;
                    e_d    = E_TOP - EW'(cnt_q) - EW'(lz_k);
                    zero_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (finish) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
`ifdef NORM_SIGNED_EN
            sign_d  = sgn_q;
`endif
        end
    end

    // State and result registers; reset aborts any operation in progress.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            r_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
            e_q     <= '0;
            zero_q  <= 1'b0;
`ifdef NORM_SIGNED_EN
            sgn_q   <= 1'b0;
            sign_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            y_q     <= y_d;
            e_q     <= e_d;
            zero_q  <= zero_d;
`ifdef NORM_SIGNED_EN
            sgn_q   <= sgn_d;
            sign_q  <= sign_d;
`endif
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign Y    = y_q;
    assign E    = e_q;
    assign ZERO = zero_q;
`ifdef NORM_SIGNED_EN
    assign SIGN = sign_q;
`else
    assign SIGN = 1'b0;
`endif

endmodule

// File: tb/tb_normalizador_iter.sv
// Self-checking bench for normalizador_iter: three instances (STEP=1,4,8)
// share stimulus and are compared against a leading-zero reference model.
module tb_normalizador_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [2:0]  busy_o, done_o, zero_o, sign_o;
    logic [31:0] y_o [3];
    logic [7:0]  e_o [3];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    normalizador_iter #(.W(32), .FRAC(24), .EW(8), .STEP(1)) u_s1 (
        .CLK(clk), .RST(rst), .START(start), .A(a), .BUSY(busy_o[0]), .DONE(done_o[0]),
        .Y(y_o[0]), .E(e_o[0]), .ZERO(zero_o[0]), .SIGN(sign_o[0]));
    normalizador_iter #(.W(32), .FRAC(24), .EW(8), .STEP(4)) u_s4 (
        .CLK(clk), .RST(rst), .START(start), .A(a), .BUSY(busy_o[1]), .DONE(done_o[1]),
        .Y(y_o[1]), .E(e_o[1]), .ZERO(zero_o[1]), .SIGN(sign_o[1]));
    normalizador_iter #(.W(32), .FRAC(24), .EW(8), .STEP(8)) u_s8 (
        .CLK(clk), .RST(rst), .START(start), .A(a), .BUSY(busy_o[2]), .DONE(done_o[2]),
        .Y(y_o[2]), .E(e_o[2]), .ZERO(zero_o[2]), .SIGN(sign_o[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: magnitude, sign and leading-zero count from plain arithmetic.
    task automatic model(input logic [31:0] av, output logic [31:0] mag, output int lz,
                         output logic sgn);
`ifdef NORM_SIGNED_EN
        mag = av[31] ? 32'(-av) : av;
        sgn = av[31];
`else
        mag = av;
        sgn = 1'b0;
`endif
        lz = 32;
        for (int b = 31; b >= 0; b--) begin
            if (mag[b]) begin
                lz = 31 - b;
                break;
            end
        end
    endtask

    // One operation on all instances; optionally pokes START/A while all are busy.
    task automatic run_op(input logic [31:0] av, input bit poke);
        int          steps[3] = '{1, 4, 8};
        int          done_at[3] = '{0, 0, 0};
        int          pulses[3] = '{0, 0, 0};
        logic [31:0] yc[3];
        logic [7:0]  ec[3];
        logic        zc[3], sc[3], bc[3];
        logic [31:0] mag, ye;
        logic [7:0]  ee;
        logic        se;
        int          lz, ev, edge_exp;
        model(av, mag, lz, se);
        ye = (mag == 0) ? 32'd0 : (mag << lz);
        ev = (mag == 0) ? 0 : 7 - lz;
        ee = ev[7:0];
        @(negedge clk);
        a = av;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        chk("busy_after_accept", {29'd0, busy_o}, 32'd7);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (done_o[i]) begin
                    pulses[i]++;
                    done_at[i] = c;
                    yc[i] = y_o[i];
                    ec[i] = e_o[i];
                    zc[i] = zero_o[i];
                    sc[i] = sign_o[i];
                    bc[i] = busy_o[i];
                end
            end
            if (done_at[0] != 0 && done_at[1] != 0 && done_at[2] != 0) break;
            if (poke && (&busy_o)) begin
                start = 1'b1;
                a = $urandom;
            end
        end
        for (int i = 0; i < 3; i++) begin
            edge_exp = (mag == 0) ? 1 : 1 + lz / steps[i];
            chk($sformatf("s%0d_done_edge a=%h", steps[i], av), done_at[i], edge_exp);
            chk($sformatf("s%0d_pulses a=%h", steps[i], av), pulses[i], 1);
            if (pulses[i] != 0) begin
                chk($sformatf("s%0d_y a=%h", steps[i], av), yc[i], ye);
                chk($sformatf("s%0d_e a=%h", steps[i], av), {24'd0, ec[i]}, {24'd0, ee});
                chk($sformatf("s%0d_zero a=%h", steps[i], av), {31'd0, zc[i]}, {31'd0, mag == 0});
                chk($sformatf("s%0d_sign a=%h", steps[i], av), {31'd0, sc[i]},
                    {31'd0, se && (mag != 0)});
                chk($sformatf("s%0d_busy_at_done a=%h", steps[i], av), {31'd0, bc[i]}, 32'd0);
            end
        end
    endtask

    task automatic chk_reset_values(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_y%0d", tag, i), y_o[i], 32'd0);
            chk($sformatf("%s_e%0d", tag, i), {24'd0, e_o[i]}, 32'd0);
        end
        chk({tag, "_flags"}, {20'd0, busy_o, done_o, zero_o, sign_o}, 32'd0);
    endtask

    initial begin
        logic [8:0] seen_mask;
        logic [8:0] exp_mask;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed cases with explicit expectations on the STEP=4 instance.
        run_op(32'h08F2_12D7, 1'b0);
        chk("dir1_y", y_o[1], 32'h8F21_2D70);
        chk("dir1_e", {24'd0, e_o[1]}, 32'd3);
        run_op(32'h0670_13A9, 1'b0);
        chk("dir2_y", y_o[1], 32'hCE02_7520);
        chk("dir2_e", {24'd0, e_o[1]}, 32'd2);
        run_op(32'h0000_0000, 1'b0);
        chk("dir3_zero", {31'd0, zero_o[1]}, 32'd1);
        run_op(32'h0000_0001, 1'b0);
        chk("dir4_y", y_o[1], 32'h8000_0000);
        chk("dir4_e", {24'd0, e_o[1]}, 32'h0000_00E8);
`ifdef NORM_SIGNED_EN
        run_op(32'hFFFF_FFFF, 1'b0);
        chk("sgn1_sign", {31'd0, sign_o[1]}, 32'd1);
        chk("sgn1_y", y_o[1], 32'h8000_0000);
        chk("sgn1_e", {24'd0, e_o[1]}, 32'h0000_00E8);
        run_op(32'h8000_0000, 1'b0);
        chk("sgn2_sign", {31'd0, sign_o[1]}, 32'd1);
        chk("sgn2_y", y_o[1], 32'h8000_0000);
        chk("sgn2_e", {24'd0, e_o[1]}, 32'd7);
`endif

        // Single-bit sweep, with START pokes while busy.
        for (int n = 0; n < 32; n++) run_op(32'd1 << n, 1'b1);

        // Random operands with varied leading-zero counts.
        for (int k = 0; k < 30; k++) run_op($urandom >> $urandom_range(0, 31), k[0]);

        // START held high: STEP=4 instance restarts each IDLE cycle (done every 3 edges for lz=4).
        @(negedge clk);
        a = 32'h08F2_12D7;
        start = 1'b1;
        @(posedge clk);
        seen_mask = '0;
        exp_mask = '0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            seen_mask[c-1] = done_o[1];
            exp_mask[c-1] = ((c % 3) == 2);
        end
        chk("held_start_done_pattern", {23'd0, seen_mask}, {23'd0, exp_mask});
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(posedge clk);

        // Reset mid-operation: abort, no DONE, reset values; then a clean operation.
        @(negedge clk);
        a = 32'h0000_0001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_no_done", {29'd0, done_o}, 32'd0);
        rst = 1'b1;
        #1;
        chk_reset_values("abort");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen_mask = '0;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk);
            #1;
            seen_mask[c] = |done_o;
        end
        chk("post_reset_no_done", {23'd0, seen_mask}, 32'd0);
        run_op(32'h08F2_12D7, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/normalizador_iter.md
# normalizador_iter

Parametrised, multi-cycle fixed-point normaliser for the natural-logarithm datapath. It accepts a W-bit fixed-point operand with FRAC fractional bits and left-shifts it until the MSB is 1. It returns the normalised mantissa, a signed binary exponent, and zero/sign flags. It replaces the single-width combinational normaliser. Shift granularity per cycle, widths and binary-point position are configurable, with a start/busy/done handshake.

## Interface
- `W`, 32, operand and mantissa width in bits (≥8).
- `FRAC`, 24, fractional bits of the input; binary point sits between bits FRAC and FRAC-1 (0 ≤ FRAC ≤ W-1).
- `EW`, 8, width of signed exponent output; must represent −FRAC … W−1−FRAC.
- `STEP`, 4, maximum left shift per cycle; one of 1, 2, 4, 8; STEP ≤ W.
- `CLK`  in  1  clock; all state on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `START`  in  1  request; sampled only in IDLE.
- `A`  in  W  operand, sampled with START.
- `BUSY`  out  1  high from the edge after START acceptance until the DONE edge.
- `DONE`  out  1  one-cycle pulse; result outputs valid from this cycle.
- `Y`  out  W  normalised mantissa (Y[W-1]=1 unless ZERO).
- `E`  out  EW  signed exponent; value(A) = Y·2^(E−(W−1)).
- `ZERO`  out  1  operand (magnitude) was zero.
- `SIGN`  out  1  operand sign (see Configuration).

## Operation
- States: IDLE, NORM.
- IDLE + START: R ← magnitude(A), CNT ← 0, SGN captured, BUSY ← 1, state ← NORM. START in NORM is ignored; A is not re-sampled.
- NORM, each cycle, evaluated in order:
  - R == 0: finish with Y=0, E=0, ZERO=1.
  - R[W-1] == 1: finish with Y=R, E=(W−1−FRAC)−CNT.
  - Top STEP bits of R all zero: R ← R<<STEP, CNT ← CNT+STEP, and stay in NORM.
  - Otherwise, let k = leading-zero count within the top STEP bits (1 ≤ k < STEP). Finish with Y=R<<k, E=(W−1−FRAC)−(CNT+k).
- Finish means: Y/E/ZERO/SIGN registered, DONE ← 1 for one cycle, BUSY ← 0, state ← IDLE.
- Outputs hold their values until the next finish or reset.
- CNT is ⌈log2(W+1)⌉ bits wide. E is computed as sign-extended two's complement and truncated to EW bits; an undersized EW is a configuration error, not a runtime condition.
- A shift by STEP never occurs when R[W-1]=1, so no set bit is ever lost.

## Timing
- Reset values: state=IDLE, BUSY=0, DONE=0, Y=0, E=0, ZERO=0, SIGN=0.
- Let edge 0 be the edge that accepts START, and lz the leading-zero count of magnitude(A).
- DONE is high after edge 1+⌊lz/STEP⌋ and is registered, not combinational. Zero operand: DONE after edge 1.
- Worst case (lz=W−1): 1+⌊(W−1)/STEP⌋ edges; W=32, STEP=4 gives 8.
- Back-to-back operation: START may be asserted in the DONE cycle (state already IDLE) and is accepted at that cycle's edge.
- A START held high continuously restarts on every IDLE cycle.
- RST asserted mid-operation aborts immediately. No DONE is produced and all outputs return to their reset values.

## Configuration
- `NORM_SIGNED_EN` defined: A is two's complement, magnitude(A)=|A|, SIGN=A[W-1] captured at START. −2^(W−1) maps to magnitude 2^(W−1) (lz=0, E=W−1−FRAC). A zero operand gives SIGN=0.
- `NORM_SIGNED_EN` undefined: A is unsigned, magnitude(A)=A, SIGN constantly 0, and no negation logic is generated.

## Test plan
- Defaults, A=32'h08F2_12D7 (lz=4) → DONE after edge 2, Y=32'h8F21_2D70, E=3, ZERO=0.
- Defaults, A=32'h0670_13A9 (lz=5) → DONE after edge 2, Y=32'hCE02_7520, E=2.
- Defaults, A=0 → DONE after edge 1, ZERO=1, Y=0, E=0. Then A=32'h0000_0001 → DONE after edge 8, Y=32'h8000_0000, E=−24.
- STEP=1 and STEP=8 sweep over random A, plus A=1<<n for n=0..31. Y and E must match a reference LZC model, and DONE edge must be 1+⌊lz/STEP⌋. START pulses while BUSY must have no effect.
- With `NORM_SIGNED_EN`: A=32'hFFFF_FFFF → SIGN=1, Y=32'h8000_0000, E=−24. A=32'h8000_0000 → SIGN=1, Y=32'h8000_0000, E=7.
- RST pulsed at edge 3 of an A=1 operation → no DONE, outputs return to reset values. A new START after RST release completes normally.
